// File: rtl/trap_csr_unit.sv
// Machine-mode trap commit stage: owns mstatus/mtvec/mepc/mcause/mtval and issues fetch redirects.
// Optional macro TRAP_VECTORED_EN enables vectored trap mode (mtvec[1:0] == 1).
module trap_csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_value_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_valid_i,
  output logic        req_ready_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] trap_base_o,
  output logic [1:0]  trap_mode_o
);

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  typedef enum logic [1:0] {
    StIdle,
    StTrapSave,
    StMretRestore,
    StRedirect
  } state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [29:0] mtvec_base_q, mtvec_base_d;
  logic [31:0] cap_cause_q, cap_cause_d;
  logic [31:0] cap_value_q, cap_value_d;
  logic [29:0] cap_pc_q, cap_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]  mtvec_mode;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic [31:0] mstatus;

  // The faulting PC is stored word-aligned, so its low bits never matter.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^trap_pc_i[1:0];

`ifdef TRAP_VECTORED_EN
  logic [1:0] mtvec_mode_q, mtvec_mode_d;
  assign mtvec_mode = mtvec_mode_q;
`else
  assign mtvec_mode = 2'b00;
`endif

  assign trap_base = {mtvec_base_q, 2'b00};
  assign mstatus   = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    trap_target = trap_base;
`ifdef TRAP_VECTORED_EN
    if (mtvec_mode == 2'b01 && cap_cause_q[31]) begin
      trap_target = trap_base + {25'b0, cap_cause_q[4:0], 2'b00};
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mtvec_base_d  = mtvec_base_q;
    cap_cause_d   = cap_cause_q;
    cap_value_d   = cap_value_q;
    cap_pc_d      = cap_pc_q;
    redirect_pc_d = redirect_pc_q;
`ifdef TRAP_VECTORED_EN
    mtvec_mode_d  = mtvec_mode_q;
`endif

    case (state_q)
      StIdle: begin
        if (trap_valid_i) begin
          cap_cause_d = trap_cause_i;
          cap_value_d = trap_value_i;
          cap_pc_d    = trap_pc_i[31:2];
          state_d     = StTrapSave;
        end else if (mret_valid_i) begin
          state_d = StMretRestore;
        end else if (csr_we_i) begin
          case (csr_addr_i)
            CsrMstatus: begin
              mie_d  = csr_wdata_i[3];
              mpie_d = csr_wdata_i[7];
            end
            CsrMtvec: begin
              mtvec_base_d = csr_wdata_i[31:2];
`ifdef TRAP_VECTORED_EN
              // WARL: only direct (0) and vectored (1) are legal modes.
              mtvec_mode_d = (csr_wdata_i[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
            end
            CsrMepc:   mepc_d   = {csr_wdata_i[31:2], 2'b00};
            CsrMcause: mcause_d = csr_wdata_i;
            CsrMtval:  mtval_d  = csr_wdata_i;
            default: ;
          endcase
        end
      end
      StTrapSave: begin
        mepc_d        = {cap_pc_q, 2'b00};
        mcause_d      = cap_cause_q;
        mtval_d       = cap_value_q;
        mpie_d        = mie_q;
        mie_d         = 1'b0;
        redirect_pc_d = trap_target;
        state_d       = StRedirect;
      end
      StMretRestore: begin
        mie_d         = mpie_q;
        mpie_d        = 1'b1;
        redirect_pc_d = mepc_q;
        state_d       = StRedirect;
      end
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mepc_q        <= 32'h0;
      mcause_q      <= 32'h0;
      mtval_q       <= 32'h0;
      mtvec_base_q  <= MTVEC_RESET[31:2];
      cap_cause_q   <= 32'h0;
      cap_value_q   <= 32'h0;
      cap_pc_q      <= 30'h0;
      redirect_pc_q <= 32'h0;
`ifdef TRAP_VECTORED_EN
      mtvec_mode_q  <= MTVEC_RESET[1:0];
`endif
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mtvec_base_q  <= mtvec_base_d;
      cap_cause_q   <= cap_cause_d;
      cap_value_q   <= cap_value_d;
      cap_pc_q      <= cap_pc_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef TRAP_VECTORED_EN
      mtvec_mode_q  <= mtvec_mode_d;
`endif
    end
  end

  // Reads show pre-write state; a same-cycle write lands on the next edge.
  always_comb begin
    csr_rdata_o = 32'h0;
    case (csr_addr_i)
      CsrMstatus: csr_rdata_o = mstatus;
      CsrMtvec:   csr_rdata_o = {mtvec_base_q, mtvec_mode};
      CsrMepc:    csr_rdata_o = mepc_q;
      CsrMcause:  csr_rdata_o = mcause_q;
      CsrMtval:   csr_rdata_o = mtval_q;
      default:    csr_rdata_o = 32'h0;
    endcase
  end

  assign req_ready_o      = (state_q == StIdle);
  assign redirect_valid_o = (state_q == StRedirect);
  assign redirect_pc_o    = redirect_pc_q;
  assign mstatus_o        = mstatus;
  assign trap_base_o      = trap_base;
  assign trap_mode_o      = mtvec_mode;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: timestamped transaction model plus directed literal expectations.
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_value_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic        mret_valid_i = 1'b0;
  logic        req_ready_o;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] mstatus_o;
  logic [31:0] trap_base_o;
  logic [1:0]  trap_mode_o;

  always #5 clk = ~clk;

  trap_csr_unit dut (
    .clk              (clk),
    .reset            (reset),
    .trap_valid_i     (trap_valid_i),
    .trap_cause_i     (trap_cause_i),
    .trap_value_i     (trap_value_i),
    .trap_pc_i        (trap_pc_i),
    .mret_valid_i     (mret_valid_i),
    .req_ready_o      (req_ready_o),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (csr_rdata_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .mstatus_o        (mstatus_o),
    .trap_base_o      (trap_base_o),
    .trap_mode_o      (trap_mode_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: each accepted request is a timestamped transaction whose
  // results become visible two cycles after acceptance.
  bit          m_mie, m_mpie, model_ok, have_pend;
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_rpc;
  bit          p_mie, p_mpie;
  logic [31:0] p_mepc, p_mcause, p_mtval, p_rpc;
  int          cyc = 0;
  int          free_from = 0;
  int          redir_at = -1;

  function automatic logic [31:0] m_mstatus();
    return 32'h1800 | {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus();
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] cause);
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 32'(cause[4:0]) * 4;
`endif
    return base;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_mie = 0; m_mpie = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_mtvec = 32'h100; have_pend = 0; redir_at = -1; free_from = cyc + 1; model_ok = 1;
    end else if (cyc >= free_from) begin
      if (trap_valid_i || mret_valid_i) begin
        p_mie = m_mie; p_mpie = m_mpie; p_mepc = m_mepc; p_mcause = m_mcause; p_mtval = m_mtval;
        if (trap_valid_i) begin
          p_mepc = trap_pc_i & ~32'h3; p_mcause = trap_cause_i; p_mtval = trap_value_i;
          p_mpie = m_mie; p_mie = 0; p_rpc = m_target(trap_cause_i);
        end else begin
          p_mie = m_mpie; p_mpie = 1; p_rpc = m_mepc;
        end
        have_pend = 1; redir_at = cyc + 2; free_from = cyc + 3;
      end else if (csr_we_i) begin
        case (csr_addr_i)
          12'h300: begin m_mie = csr_wdata_i[3]; m_mpie = csr_wdata_i[7]; end
`ifdef TRAP_VECTORED_EN
          12'h305: m_mtvec = {csr_wdata_i[31:2], (csr_wdata_i[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
          12'h305: m_mtvec = {csr_wdata_i[31:2], 2'b00};
`endif
          12'h341: m_mepc = csr_wdata_i & ~32'h3;
          12'h342: m_mcause = csr_wdata_i;
          12'h343: m_mtval = csr_wdata_i;
          default: ;
        endcase
      end
    end
    cyc++;
    if (have_pend && cyc == redir_at) begin
      m_mie = p_mie; m_mpie = p_mpie; m_mepc = p_mepc; m_mcause = p_mcause; m_mtval = p_mtval;
      m_rpc = p_rpc; have_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("ready", {31'b0, req_ready_o}, {31'b0, cyc >= free_from});
      chk("redirect_valid", {31'b0, redirect_valid_o}, {31'b0, cyc == redir_at});
      if (cyc == redir_at) chk("redirect_pc", redirect_pc_o, m_rpc);
      chk("mstatus_o", mstatus_o, m_mstatus());
      chk("trap_base_o", trap_base_o, m_mtvec & ~32'h3);
      chk("trap_mode_o", {30'b0, trap_mode_o}, {30'b0, m_mtvec[1:0]});
      chk("csr_rdata_o", csr_rdata_o, m_read(csr_addr_i));
    end
  end

  task automatic idle(input int n);
    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344};
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      csr_addr_i = addrs[i % 6];
    end
  endtask

  task automatic read_csr(input logic [11:0] a, input logic [31:0] exp, input string name);
    csr_addr_i = a;
    #1;
    chk(name, csr_rdata_o, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr_i = a; csr_wdata_i = d; csr_we_i = 1'b1;
    @(posedge clk); #1;
    csr_we_i = 1'b0;
  endtask

  task automatic trap_begin(input logic [31:0] cause, input logic [31:0] value,
                            input logic [31:0] pc);
    trap_cause_i = cause; trap_value_i = value; trap_pc_i = pc; trap_valid_i = 1'b1;
    @(posedge clk); #1;
    trap_valid_i = 1'b0;
  endtask

  task automatic wait_redirect(input logic [31:0] exp, input string name);
    int lat = 0;
    bit seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (redirect_valid_o === 1'b1) seen = 1;
    end
    chk({name, " seen"}, {31'b0, seen}, 32'd1);
    chk({name, " latency"}, lat, 32'd2);
    chk({name, " pc"}, redirect_pc_o, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pulses;
    bit  acc;
    logic [31:0] exp_vec;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset ready", {31'b0, req_ready_o}, 32'd1);
    chk("reset redirect_valid", {31'b0, redirect_valid_o}, 32'd0);
    chk("reset redirect_pc", redirect_pc_o, 32'h0);
    chk("reset mstatus", mstatus_o, 32'h1800);
    read_csr(12'h305, 32'h100, "reset mtvec");

    // mstatus write mask
    csr_write(12'h300, 32'hFFFF_FFFF);
    read_csr(12'h300, 32'h1888, "mstatus mask");
    csr_write(12'h300, 32'h8);
    read_csr(12'h300, 32'h1808, "mstatus mie");

    // Exception, with a CSR write attempted while busy
    trap_begin(32'd2, 32'hDEAD_BEEF, 32'h2002);
    csr_addr_i = 12'h343; csr_wdata_i = 32'h1234; csr_we_i = 1'b1;
    wait_redirect(32'h100, "exc");
    csr_we_i = 1'b0;
    read_csr(12'h341, 32'h2000, "exc mepc");
    read_csr(12'h342, 32'h2, "exc mcause");
    read_csr(12'h343, 32'hDEAD_BEEF, "exc mtval");
    read_csr(12'h300, 32'h1880, "exc mstatus");
    idle(3);

    // Vectored interrupt
`ifdef TRAP_VECTORED_EN
    exp_vec = 32'h22C;
    csr_write(12'h305, 32'h201);
    read_csr(12'h305, 32'h201, "mtvec vectored");
`else
    exp_vec = 32'h200;
    csr_write(12'h305, 32'h201);
    read_csr(12'h305, 32'h200, "mtvec vectored");
`endif
    trap_begin(32'h8000_000B, 32'h0, 32'h4000);
    wait_redirect(exp_vec, "vec irq");
    idle(1);
    trap_begin(32'h0000_000B, 32'h0, 32'h4004);
    wait_redirect(32'h200, "vec exc");
    idle(1);
    // Wrapping vector target
    csr_write(12'h305, 32'hFFFF_FFFD);
`ifdef TRAP_VECTORED_EN
    exp_vec = 32'h78;
`else
    exp_vec = 32'hFFFF_FFFC;
`endif
    trap_begin(32'h8000_001F, 32'h0, 32'h4008);
    wait_redirect(exp_vec, "vec wrap");
    idle(1);
    csr_write(12'h305, 32'h203);
    read_csr(12'h305, 32'h200, "mtvec warl 3");
    csr_write(12'h305, 32'h102);
    read_csr(12'h305, 32'h100, "mtvec warl 2");

    // MRET
    csr_write(12'h341, 32'h3003);
    read_csr(12'h341, 32'h3000, "mepc align");
    csr_write(12'h300, 32'h80);
    mret_valid_i = 1'b1;
    @(posedge clk); #1;
    mret_valid_i = 1'b0;
    wait_redirect(32'h3000, "mret");
    read_csr(12'h300, 32'h1888, "mret mstatus");
    idle(2);

    // Simultaneous trap + mret + csr write
    trap_cause_i = 32'd5; trap_value_i = 32'h77; trap_pc_i = 32'h5004;
    trap_valid_i = 1'b1; mret_valid_i = 1'b1;
    csr_we_i = 1'b1; csr_addr_i = 12'h342; csr_wdata_i = 32'h55;
    @(posedge clk); #1;
    trap_valid_i = 1'b0; csr_we_i = 1'b0;
    wait_redirect(32'h100, "simul trap");
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (req_ready_o === 1'b1) begin
        @(posedge clk); #1;
        mret_valid_i = 1'b0;
        acc = 1;
      end
    end
    mret_valid_i = 1'b0;
    chk("simul mret accepted", {31'b0, acc}, 32'd1);
    wait_redirect(32'h5004, "simul mret");
    read_csr(12'h342, 32'h5, "simul mcause");
    read_csr(12'h300, 32'h1888, "simul mstatus");

    // Unmapped address
    idle(1);
    csr_write(12'h344, 32'hFFFF);
    read_csr(12'h344, 32'h0, "unmapped");

    // Reset during TRAP_SAVE
    trap_begin(32'd7, 32'h99, 32'h6000);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (redirect_valid_o !== 1'b0) pulses++;
    end
    chk("abort no redirect", pulses, 32'd0);
    chk("abort ready", {31'b0, req_ready_o}, 32'd1);
    read_csr(12'h300, 32'h1800, "abort mstatus");
    read_csr(12'h305, 32'h100, "abort mtvec");
    read_csr(12'h341, 32'h0, "abort mepc");
    read_csr(12'h342, 32'h0, "abort mcause");
    read_csr(12'h343, 32'h0, "abort mtval");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
